// File: rtl/key_entry_reg_if.sv
// Keypad-entry bus: tick/key/clear requests into the entry register and the
// HH:MM digit buffer plus status pulses back out.
interface key_entry_reg_if;
    logic       one_second;
    logic [3:0] key;
    logic       clear_entry;
    logic [3:0] new_ms_hour;
    logic [3:0] new_ls_hour;
    logic [3:0] new_ms_minute;
    logic [3:0] new_ls_minute;
    logic [2:0] digit_count;
    logic       entry_active;
    logic       entry_done;
    logic       timeout;

    modport master (
        output one_second, key, clear_entry,
        input  new_ms_hour, new_ls_hour, new_ms_minute, new_ls_minute,
        input  digit_count, entry_active, entry_done, timeout
    );

    modport slave (
        input  one_second, key, clear_entry,
        output new_ms_hour, new_ls_hour, new_ms_minute, new_ls_minute,
        output digit_count, entry_active, entry_done, timeout
    );
endinterface

// File: rtl/key_entry_reg.sv
// Keypad debouncer feeding a 4-digit shift-in HH:MM entry buffer, with an
// inactivity timeout counted in one-second ticks.
module key_entry_reg #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_SECS    = 10
) (
    input  logic          clock,
    input  logic          reset,
    key_entry_reg_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, WAIT_RELEASE} state_e;

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_SECS);

    state_e           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [7:0]       db_cnt_q, db_cnt_d;
    logic             accept;
    logic             key_is_digit;

    logic [3:0][3:0]  digits_q, digits_d;
    logic [2:0]       count_q, count_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic             tout_q, tout_d;
    logic [7:0]       sec_q, sec_d;

    assign key_is_digit = (bus.key <= 4'd9);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cand_q   <= 4'd0;
            db_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // db_cnt counts matching samples in DEBOUNCE and NOKEY samples in WAIT_RELEASE.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        db_cnt_d = db_cnt_q;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_is_digit) begin
                    cand_d = bus.key;
                    if (DB_LAST == 8'd1) begin
                        accept   = 1'b1;
                        db_cnt_d = 8'd0;
                        state_d  = WAIT_RELEASE;
                    end else begin
                        db_cnt_d = 8'd1;
                        state_d  = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (bus.key == cand_q) begin
                    if (db_cnt_q + 8'd1 == DB_LAST) begin
                        accept   = 1'b1;
                        db_cnt_d = 8'd0;
                        state_d  = WAIT_RELEASE;
                    end else begin
                        db_cnt_d = db_cnt_q + 8'd1;
                    end
                end else if (key_is_digit) begin
                    cand_d   = bus.key;
                    db_cnt_d = 8'd1;
                end else begin
                    db_cnt_d = 8'd0;
                    state_d  = IDLE;
                end
            end
            WAIT_RELEASE: begin
                if (!key_is_digit) begin
                    if (db_cnt_q + 8'd1 == DB_LAST) begin
                        db_cnt_d = 8'd0;
                        state_d  = IDLE;
                    end else begin
                        db_cnt_d = db_cnt_q + 8'd1;
                    end
                end else begin
                    db_cnt_d = 8'd0;
                end
            end
            default: begin
                db_cnt_d = 8'd0;
                state_d  = IDLE;
            end
        endcase
    end

    // Buffer priority: clear_entry, then accept, then timeout expiry.
    always_comb begin
        digits_d = digits_q;
        count_d  = count_q;
        active_d = active_q;
        sec_d    = sec_q;
        done_d   = 1'b0;
        tout_d   = 1'b0;
        if (bus.clear_entry) begin
            digits_d = '0;
            count_d  = 3'd0;
            active_d = 1'b0;
            sec_d    = 8'd0;
        end else if (accept) begin
            digits_d = {digits_q[2:0], bus.key};
            count_d  = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
            active_d = 1'b1;
            done_d   = (count_q == 3'd3);
            sec_d    = 8'd0;
        end else if (active_q && bus.one_second) begin
            if (sec_q + 8'd1 == TO_LAST) begin
                digits_d = '0;
                count_d  = 3'd0;
                active_d = 1'b0;
                sec_d    = 8'd0;
                tout_d   = 1'b1;
            end else begin
                sec_d = sec_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            digits_q <= '0;
            count_q  <= 3'd0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            tout_q   <= 1'b0;
            sec_q    <= 8'd0;
        end else begin
            digits_q <= digits_d;
            count_q  <= count_d;
            active_q <= active_d;
            done_q   <= done_d;
            tout_q   <= tout_d;
            sec_q    <= sec_d;
        end
    end

    assign bus.new_ms_hour   = digits_q[3];
    assign bus.new_ls_hour   = digits_q[2];
    assign bus.new_ms_minute = digits_q[1];
    assign bus.new_ls_minute = digits_q[0];
    assign bus.digit_count   = count_q;
    assign bus.entry_active  = active_q;
    assign bus.entry_done    = done_q;
    assign bus.timeout       = tout_q;
endmodule

// File: tb/tb_key_entry_reg.sv
// Scoreboard bench: stimulus queues each expected output snapshot with the
// cycle it must appear on; a negedge monitor pops on every output change.
module tb_key_entry_reg;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    key_entry_reg_if bus();

    key_entry_reg #(.DEBOUNCE_CYCLES(4), .TIMEOUT_SECS(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [21:0] snap;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    bit          mon_en   = 1'b0;
    logic [21:0] prev;
    logic [21:0] snap;

    assign snap = {bus.new_ms_hour, bus.new_ls_hour, bus.new_ms_minute, bus.new_ls_minute,
                   bus.digit_count, bus.entry_active, bus.entry_done, bus.timeout};

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [21:0] mk(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic [3:0] d,
                                       input logic [2:0] n, input logic act,
                                       input logic dn, input logic to);
        return {a, b, c, d, n, act, dn, to};
    endfunction

    task automatic expect_at(input logic [21:0] s, input int unsigned dly);
        exp_t e;
        e.snap = s;
        e.cyc  = cyc + dly;
        q.push_back(e);
    endtask

    // Monitor: every visible output change must match the head of the queue.
    always @(negedge clock) begin
        if (mon_en && snap !== prev) begin
            exp_t e;
            prev = snap;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change got=%h at cyc %0d, no change required", snap, cyc);
            end else begin
                e = q.pop_front();
                if (snap !== e.snap || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL out_seq got=%h@cyc%0d required=%h@cyc%0d", snap, cyc, e.snap, e.cyc);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] k, input int n);
        bus.key = k;
        repeat (n) @(negedge clock);
    endtask

    task automatic enter(input logic [3:0] k, input logic [21:0] s);
        expect_at(s, 4);
        drive(k, 6);
        drive(4'hF, 6);
    endtask

    task automatic tick();
        bus.one_second = 1'b1;
        @(negedge clock);
        bus.one_second = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_clear(input bit expect_change);
        if (expect_change) expect_at('0, 1);
        bus.clear_entry = 1'b1;
        @(negedge clock);
        bus.clear_entry = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.key = 4'hF;
        bus.clear_entry = 1'b0;
        bus.one_second = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checks++;
        if (snap !== 22'h0) begin
            failures++;
            $display("FAIL reset_state got=%h required=%h", snap, 22'h0);
        end
        prev = snap;
        mon_en = 1'b1;
        drive(4'hF, 2);

        // 1: four digits, entry_done on the 4th only
        enter(4'd1, mk(0, 0, 0, 1, 1, 1, 0, 0));
        enter(4'd2, mk(0, 0, 1, 2, 2, 1, 0, 0));
        enter(4'd3, mk(0, 1, 2, 3, 3, 1, 0, 0));
        expect_at(mk(1, 2, 3, 4, 4, 1, 1, 0), 4);
        expect_at(mk(1, 2, 3, 4, 4, 1, 0, 0), 5);
        drive(4'd4, 6);
        drive(4'hF, 6);
        do_clear(1);

        // 2: short press rejected, then bouncy press accepted on 4th stable 5
        drive(4'd5, 3);
        drive(4'hF, 6);
        expect_at(mk(0, 0, 0, 5, 1, 1, 0, 0), 6);
        drive(4'd5, 1);
        drive(4'd7, 1);
        drive(4'd5, 4);
        drive(4'hF, 6);
        do_clear(1);

        // 3: long hold, single accept
        enter(4'd8, mk(0, 0, 0, 8, 1, 1, 0, 0));
        expect_at(mk(0, 0, 0, 8, 1, 1, 0, 0), 0);
        q.delete(q.size() - 1);
        do_clear(1);
        q.delete();
        expect_at(mk(0, 0, 0, 8, 1, 1, 0, 0), 4);
        drive(4'd8, 50);
        drive(4'hF, 6);
        do_clear(1);

        // 4: timeout on the 10th tick
        enter(4'd2, mk(0, 0, 0, 2, 1, 1, 0, 0));
        enter(4'd3, mk(0, 0, 2, 3, 2, 1, 0, 0));
        repeat (9) tick();
        expect_at(mk(0, 0, 0, 0, 0, 0, 0, 1), 1);
        expect_at(mk(0, 0, 0, 0, 0, 0, 0, 0), 2);
        tick();
        drive(4'hF, 3);

        // clear_entry on the accepting edge: digit lost, buffer stays empty
        drive(4'd9, 3);
        bus.clear_entry = 1'b1;
        drive(4'd9, 1);
        bus.clear_entry = 1'b0;
        drive(4'd9, 2);
        drive(4'hF, 6);

        // 5: fifth digit drops the oldest, done pulses once only
        enter(4'd1, mk(0, 0, 0, 1, 1, 1, 0, 0));
        enter(4'd2, mk(0, 0, 1, 2, 2, 1, 0, 0));
        enter(4'd3, mk(0, 1, 2, 3, 3, 1, 0, 0));
        expect_at(mk(1, 2, 3, 4, 4, 1, 1, 0), 4);
        expect_at(mk(1, 2, 3, 4, 4, 1, 0, 0), 5);
        drive(4'd4, 6);
        drive(4'hF, 6);
        enter(4'd5, mk(2, 3, 4, 5, 4, 1, 0, 0));
        do_clear(1);

        // accept on the timeout-expiry edge wins and restarts the counter
        enter(4'd1, mk(0, 0, 0, 1, 1, 1, 0, 0));
        repeat (9) tick();
        expect_at(mk(0, 0, 1, 2, 2, 1, 0, 0), 4);
        drive(4'd2, 3);
        bus.one_second = 1'b1;
        drive(4'd2, 1);
        bus.one_second = 1'b0;
        drive(4'd2, 2);
        drive(4'hF, 6);
        repeat (9) tick();
        expect_at(mk(0, 0, 0, 0, 0, 0, 0, 1), 1);
        expect_at(mk(0, 0, 0, 0, 0, 0, 0, 0), 2);
        tick();
        drive(4'hF, 3);

        // 6: reset mid-debounce after two digits, then a fresh press
        enter(4'd1, mk(0, 0, 0, 1, 1, 1, 0, 0));
        enter(4'd2, mk(0, 0, 1, 2, 2, 1, 0, 0));
        drive(4'd6, 2);
        expect_at('0, 1);
        reset = 1'b1;
        drive(4'd6, 1);
        drive(4'hF, 1);
        reset = 1'b0;
        drive(4'hF, 3);
        enter(4'd7, mk(0, 0, 0, 7, 1, 1, 0, 0));

        drive(4'hF, 10);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_expected got=%0d outstanding required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
